adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbitrated adder: grants one requester at a time, computes a+b+cin
// with carry-out and signed overflow, and holds the result until it is accepted.
module adder_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_overflow,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             opCin_q, opCin_d;
  logic [ID_W-1:0]  opId_q, opId_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [ID_W-1:0]  rspId_q, rspId_d;

  logic             grantFound;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    cand;
  logic [ID_W:0]    nextPtr;
  logic [WIDTH-1:0] selA, selB;
  logic             selCin;
  logic [WIDTH:0]   fullSum;

  // Search upward from rrPtr with wrap-around; the first valid index wins.
  always_comb begin
    grantFound = 1'b0;
    winner     = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rrPtr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grantFound && req_valid[cand[ID_W-1:0]]) begin
        grantFound = 1'b1;
        winner     = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    selA   = '0;
    selB   = '0;
    selCin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        selA   = req_a[i*WIDTH +: WIDTH];
        selB   = req_b[i*WIDTH +: WIDTH];
        selCin = req_cin[i];
      end
    end
  end

  assign fullSum = {1'b0, opA_q} + {1'b0, opB_q} + {{WIDTH{1'b0}}, opCin_q};

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    opCin_d   = opCin_q;
    opId_d    = opId_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    rspId_d   = rspId_q;
    req_ready = '0;
    nextPtr   = {1'b0, winner} + (ID_W+1)'(1);
    if (nextPtr == (ID_W+1)'(NUM_REQ)) nextPtr = '0;
    case (state_q)
      IDLE: begin
        if (grantFound) begin
          req_ready[winner] = 1'b1;
          opA_d   = selA;
          opB_d   = selB;
          opCin_d = selCin;
          opId_d  = winner;
          rrPtr_d = nextPtr[ID_W-1:0];
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = fullSum[WIDTH-1:0];
        cout_d  = fullSum[WIDTH];
        ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (fullSum[WIDTH-1] != opA_q[WIDTH-1]);
        rspId_d = opId_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rrPtr_q <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      opCin_q <= 1'b0;
      opId_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rspId_q <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      opCin_q <= opCin_d;
      opId_q  <= opId_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      rspId_q <= rspId_d;
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign rsp_sum      = sum_q;
  assign rsp_cout     = cout_q;
  assign rsp_overflow = ovf_q;
  assign rsp_id       = rspId_q;

endmodule
